// File: rtl/btb_set_array_if.sv
// Lookup/update/write bundle for btb_set_array.
// master: BTB lookup/update control. slave: the set array.
interface btb_set_array_if #(
    parameter int unsigned NUM_SETS  = 8,
    parameter int unsigned SET_WIDTH = 128
);
    localparam int unsigned IDX_W = $clog2(NUM_SETS);

    logic                 flush_req;
    logic [IDX_W-1:0]     read_index;
    logic [SET_WIDTH-1:0] read_set;
    logic [IDX_W-1:0]     update_index;
    logic [SET_WIDTH-1:0] update_set;
    logic                 write_enable;
    logic [IDX_W-1:0]     write_index;
    logic [SET_WIDTH-1:0] write_set;
    logic                 ready;
    logic                 read_parity_err;

    modport master (
        output flush_req, read_index, update_index, write_enable, write_index, write_set,
        input  read_set, update_set, ready, read_parity_err
    );

    modport slave (
        input  flush_req, read_index, update_index, write_enable, write_index, write_set,
        output read_set, update_set, ready, read_parity_err
    );
endinterface

// File: rtl/btb_set_array.sv
// Parametrised BTB set storage with a self-clearing walker.
// Lookup port bypasses same-cycle writes; update port reads the array only.
// Optional per-set even parity: define BTB_SET_ARRAY_PARITY_EN.
module btb_set_array #(
    parameter int unsigned NUM_SETS  = 8,
    parameter int unsigned SET_WIDTH = 128
) (
    input  logic              clk,
    input  logic              rst,
    btb_set_array_if.slave    bus
);
    localparam int unsigned IDX_W = $clog2(NUM_SETS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SETS - 1);

    typedef enum logic {StClear, StReady} state_e;

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     clr_ptr_q, clr_ptr_d;
    logic [SET_WIDTH-1:0] mem_q [NUM_SETS];
    logic                 bypass;
`ifdef BTB_SET_ARRAY_PARITY_EN
    logic                 mem_par_q [NUM_SETS];
`endif

    // State register and clear pointer; reset restarts the walk from set 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StClear;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    // Next state: walk every set once, then serve until a flush.
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        unique case (state_q)
            StClear: begin
                clr_ptr_d = clr_ptr_q + 1'b1;
                if (clr_ptr_q == LAST_IDX) begin
                    state_d = StReady;
                end
            end
            StReady: begin
                if (bus.flush_req) begin
                    state_d   = StClear;
                    clr_ptr_d = '0;
                end
            end
            default: begin
                state_d   = StClear;
                clr_ptr_d = '0;
            end
        endcase
    end

    // Array writes: the walker owns the array while clearing, user writes are dropped.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == StClear) begin
                mem_q[clr_ptr_q] <= '0;
`ifdef BTB_SET_ARRAY_PARITY_EN
                mem_par_q[clr_ptr_q] <= 1'b0;
`endif
            end else if (bus.write_enable) begin
                mem_q[bus.write_index] <= bus.write_set;
`ifdef BTB_SET_ARRAY_PARITY_EN
                mem_par_q[bus.write_index] <= ^bus.write_set;
`endif
            end
        end
    end

    assign bypass = bus.write_enable && (bus.read_index == bus.write_index);

    // Outputs: everything reads as zero until the clear has finished.
    always_comb begin
        bus.ready           = 1'b0;
        bus.read_set        = '0;
        bus.update_set      = '0;
        bus.read_parity_err = 1'b0;
        if (state_q == StReady) begin
            bus.ready      = 1'b1;
            bus.read_set   = bypass ? bus.write_set : mem_q[bus.read_index];
            bus.update_set = mem_q[bus.update_index];
`ifdef BTB_SET_ARRAY_PARITY_EN
            bus.read_parity_err = !bypass &&
                ((^mem_q[bus.read_index]) != mem_par_q[bus.read_index]);
`endif
        end
    end
endmodule

// File: tb/tb_btb_set_array.sv
// Directed bench for btb_set_array with a per-cycle reference model.
module tb_btb_set_array;
    localparam int unsigned NUM_SETS  = 8;
    localparam int unsigned SET_WIDTH = 128;
    localparam int unsigned IDX_W     = $clog2(NUM_SETS);

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    btb_set_array_if #(.NUM_SETS(NUM_SETS), .SET_WIDTH(SET_WIDTH)) bus ();

    btb_set_array #(.NUM_SETS(NUM_SETS), .SET_WIDTH(SET_WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: array contents, cycles left before ready, corrupted-parity flags.
    logic [SET_WIDTH-1:0] m_mem [NUM_SETS];
    bit                   m_bad [NUM_SETS];
    int                   clear_left  = 0;
    bit                   model_valid = 1'b0;

    task automatic check(input string name, input logic [SET_WIDTH-1:0] act,
                         input logic [SET_WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model update on each edge from the inputs the DUT sees at that edge.
    always @(posedge clk) begin
        if (rst) begin
            clear_left  = NUM_SETS;
            model_valid = 1'b1;
        end else if (model_valid) begin
            if (clear_left > 0) begin
                clear_left--;
                if (clear_left == 0) begin
                    for (int i = 0; i < NUM_SETS; i++) begin
                        m_mem[i] = '0;
                        m_bad[i] = 1'b0;
                    end
                end
            end else begin
                if (bus.write_enable) begin
                    m_mem[bus.write_index] = bus.write_set;
                    m_bad[bus.write_index] = 1'b0;
                end
                if (bus.flush_req) clear_left = NUM_SETS;
            end
        end
    end

    // Compare every cycle on the falling edge.
    always @(negedge clk) begin
        logic                 e_ready;
        logic                 e_byp;
        logic [SET_WIDTH-1:0] e_read;
        logic [SET_WIDTH-1:0] e_upd;
        logic                 e_perr;
        if (model_valid) begin
            e_ready = (clear_left == 0);
            e_byp   = bus.write_enable && (bus.read_index == bus.write_index);
            e_read  = !e_ready ? '0 : (e_byp ? bus.write_set : m_mem[bus.read_index]);
            e_upd   = e_ready ? m_mem[bus.update_index] : '0;
            e_perr  = e_ready && !e_byp && m_bad[bus.read_index];
            check("cmp_ready", SET_WIDTH'(bus.ready), SET_WIDTH'(e_ready));
            check("cmp_read_set", bus.read_set, e_read);
            check("cmp_update_set", bus.update_set, e_upd);
            check("cmp_parity_err", SET_WIDTH'(bus.read_parity_err), SET_WIDTH'(e_perr));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Count edges until ready rises; the bound keeps a stuck DUT from hanging the run.
    task automatic wait_ready(input string name, input int start);
        int n = start;
        while (!bus.ready && n < 40) begin
            step();
            n++;
        end
        check(name, SET_WIDTH'(n), SET_WIDTH'(NUM_SETS));
    endtask

    task automatic drive_write(input int idx, input logic [SET_WIDTH-1:0] data);
        bus.write_enable = 1'b1;
        bus.write_index  = IDX_W'(idx);
        bus.write_set    = data;
    endtask

    task automatic read_all_zero(input string name);
        for (int i = 0; i < NUM_SETS; i++) begin
            bus.read_index   = IDX_W'(i);
            bus.update_index = IDX_W'(NUM_SETS - 1 - i);
            #1;
            check(name, bus.read_set, '0);
            step();
        end
    endtask

    initial begin
        logic [SET_WIDTH-1:0] pat_a5;
        logic [SET_WIDTH-1:0] fill;
        pat_a5               = {16{8'hA5}};
        bus.flush_req        = 1'b0;
        bus.read_index       = '0;
        bus.update_index     = '0;
        bus.write_enable     = 1'b0;
        bus.write_index      = '0;
        bus.write_set        = '0;

        // Reset; a write to 5 and a flush during the clear must both be ignored.
        step();
        step();
        check("reset_ready_low", SET_WIDTH'(bus.ready), '0);
        rst = 1'b0;
        drive_write(5, {SET_WIDTH{1'b1}});
        bus.flush_req = 1'b1;
        step();
        bus.write_enable = 1'b0;
        bus.flush_req    = 1'b0;
        wait_ready("reset_clear_len", 1);
        bus.read_index = 3'd5;
        #1;
        check("clear_drops_write_idx5", bus.read_set, '0);
        read_all_zero("after_reset_zero");

        // Same-cycle bypass, then array read on both ports next cycle.
        drive_write(3, pat_a5);
        bus.read_index   = 3'd3;
        bus.update_index = 3'd3;
        #1;
        check("bypass_read_idx3", bus.read_set, pat_a5);
        check("update_no_bypass", bus.update_set, '0);
        step();
        bus.write_enable = 1'b0;
        #1;
        check("read_idx3_next", bus.read_set, pat_a5);
        check("update_idx3_next", bus.update_set, pat_a5);
        step();

        // Fill every set with distinct data and read back through both ports.
        for (int i = 0; i < NUM_SETS; i++) begin
            fill = {4{32'hC0DE_0000 + 32'(i)}};
            drive_write(i, fill);
            bus.read_index = IDX_W'((i + 1) % NUM_SETS);
            step();
        end
        bus.write_enable = 1'b0;
        for (int i = 0; i < NUM_SETS; i++) begin
            bus.read_index   = IDX_W'(i);
            bus.update_index = IDX_W'(NUM_SETS - 1 - i);
            step();
        end
        bus.read_index   = 3'd6;
        bus.update_index = 3'd1;
        #1;
        check("fill_read_idx6", bus.read_set, {4{32'hC0DE_0006}});
        check("fill_update_idx1", bus.update_set, {4{32'hC0DE_0001}});

        // Flush together with a write to 0: write lands, then the clear wipes it.
        drive_write(0, {4{32'hDEAD_BEEF}});
        bus.flush_req = 1'b1;
        step();
        bus.write_enable = 1'b0;
        bus.flush_req    = 1'b0;
        check("flush_ready_drop", SET_WIDTH'(bus.ready), '0);
        wait_ready("flush_clear_len", 0);
        read_all_zero("after_flush_zero");

        // Reset in the middle of a clear restarts the walk.
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("midclear_ready_low", SET_WIDTH'(bus.ready), '0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        wait_ready("midclear_restart_len", 0);

`ifdef BTB_SET_ARRAY_PARITY_EN
        // Corrupt one stored bit of set 2, then repair it with a rewrite.
        drive_write(2, {4{32'h1234_5678}});
        step();
        bus.write_enable = 1'b0;
        dut.mem_q[2][0] = ~dut.mem_q[2][0];
        m_mem[2][0]     = ~m_mem[2][0];
        m_bad[2]        = 1'b1;
        bus.read_index  = 3'd2;
        #1;
        check("parity_err_flip", SET_WIDTH'(bus.read_parity_err), SET_WIDTH'(1));
        step();
        drive_write(2, {4{32'h1234_5678}});
        #1;
        check("parity_bypass_zero", SET_WIDTH'(bus.read_parity_err), '0);
        step();
        bus.write_enable = 1'b0;
        #1;
        check("parity_err_rewrite", SET_WIDTH'(bus.read_parity_err), '0);
        step();
`endif

        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
